// File: rtl/ram_pkg.sv
// Shared types, constants and elaboration-time parameter check for ram_sp_ctrl.
package ram_pkg;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;
    localparam int unsigned LANE_W     = 8;

    function automatic bit params_ok(input int unsigned data_w, input int unsigned addr_w,
                                     input int unsigned depth, input int unsigned rd_lat);
        return (data_w >= LANE_W) && ((data_w % LANE_W) == 0) &&
               (depth >= 1) && (depth <= (32'd1 << addr_w)) &&
               (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_sp_ctrl_if.sv
// Request/response bundle between a requester (master) and ram_sp_ctrl (slave).
interface ram_sp_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    import ram_pkg::*;

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wr;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_wdata;
    logic [DATA_W/LANE_W-1:0]   req_be;
    logic                       rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ram_rd_pipe.sv
// Valid/data delay line for read responses; data only advances with its valid bit.
module ram_rd_pipe #(
    parameter int unsigned STAGES = 1,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (STAGES == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, rst};
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_pipe
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            logic              v_in;
            logic [DATA_W-1:0] d_in;
            logic              valid_q;
            logic [DATA_W-1:0] data_q;

            if (s == 0) begin : g_first
                assign v_in = in_valid;
                assign d_in = in_data;
            end else begin : g_next
                assign v_in = g_stage[s-1].valid_q;
                assign d_in = g_stage[s-1].data_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= v_in;
                    if (v_in) data_q <= d_in;
                end
            end
        end

        assign out_valid = g_stage[STAGES-1].valid_q;
        assign out_data  = g_stage[STAGES-1].data_q;
    end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port synchronous RAM with valid/ready requests, byte-enabled writes,
// RD_LAT of 1 or 2, and an optional zero-fill sequence after reset.
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DEPTH        = 2**ADDR_W,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic         clk,
    input  logic         rst,
    ram_sp_ctrl_if.slave bus,
    output logic         busy
);

    localparam int unsigned       LANES      = DATA_W / LANE_W;
    localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam state_t            INIT_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    if (!params_ok(DATA_W, ADDR_W, DEPTH, RD_LAT)) begin : g_bad_params
        $error("ram_sp_ctrl: illegal DATA_W, DEPTH or RD_LAT");
    end

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] merged;
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT_STATE;
        else     state <= state_nx;
    end

    // Outputs gated by rst so req_ready/busy read 0 while reset is held.
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = !rst;
                if (clr_cnt == LAST_ADDR) state_nx = ST_READY;
            end
            ST_READY: bus.req_ready = !rst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                    clr_cnt <= '0;
        else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    assign accept    = bus.req_valid && bus.req_ready;
    assign rd_accept = accept && !bus.req_wr;
    assign in_range  = {1'b0, bus.req_addr} < DEPTH_EXT;
    assign rd_word   = in_range ? mem[bus.req_addr] : '0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign wr_mask[g*LANE_W +: LANE_W] = {LANE_W{bus.req_be[g]}};
    end

    // Byte merge is done as a whole-word read-modify-write of the addressed word.
    assign merged = (rd_word & ~wr_mask) | (bus.req_wdata & wr_mask);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR)
                mem[clr_cnt] <= '0;
            else if (accept && bus.req_wr && in_range)
                mem[bus.req_addr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else begin
            s0_valid <= rd_accept;
            if (rd_accept) s0_data <= rd_word;
        end
    end

    ram_rd_pipe #(
        .STAGES (RD_LAT - 1),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_valid),
        .in_data   (s0_data),
        .out_valid (bus.rsp_valid),
        .out_data  (bus.rsp_rdata)
    );

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Scoreboard bench for ram_sp_ctrl across three parameter sets (A: 32b/16w/lat1,
// B: 8b/10w/lat2, C: 16b/16w/lat1 without power-on clear).
`timescale 1ns/1ps
module tb_ram_sp_ctrl;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic busy_a, busy_b, busy_c;

    int vectors = 0;
    int errors  = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic [31:0] ma [16];
    logic [7:0]  mb [16];
    logic [15:0] mc [16];

    ram_sp_ctrl_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
    ram_sp_ctrl_if #(.DATA_W(8),  .ADDR_W(4)) bus_b ();
    ram_sp_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus_c ();

    ram_sp_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RST(1))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a), .busy(busy_a));
    ram_sp_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(10), .RD_LAT(2), .CLEAR_ON_RST(1))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b), .busy(busy_b));
    ram_sp_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RST(0))
        dut_c (.clk(clk), .rst(rst_c), .bus(bus_c), .busy(busy_c));

    always #5 clk = ~clk;

    // Rising edges elapsed at a falling edge (period 10, first rise at 5).
    function automatic int cyc_now();
        return int'($time / 10);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One request on DUT `dut` (0=A, 1=B, 2=C), updating the model or queueing the expected read.
    task automatic op(input int dut, input bit wr, input logic [3:0] addr,
                      input logic [31:0] d, input logic [3:0] be);
        logic        ready;
        exp_t        e;
        logic [31:0] m32;
        logic [15:0] m16;
        case (dut)
            0:       ready = bus_a.req_ready;
            1:       ready = bus_b.req_ready;
            default: ready = bus_c.req_ready;
        endcase
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready dut%0d t=%0t: got %b, want 1", dut, $time, ready);
        end
        case (dut)
            0: begin
                bus_a.req_valid = 1'b1; bus_a.req_wr = wr; bus_a.req_addr = addr;
                bus_a.req_wdata = d; bus_a.req_be = be;
            end
            1: begin
                bus_b.req_valid = 1'b1; bus_b.req_wr = wr; bus_b.req_addr = addr;
                bus_b.req_wdata = d[7:0]; bus_b.req_be = be[0:0];
            end
            default: begin
                bus_c.req_valid = 1'b1; bus_c.req_wr = wr; bus_c.req_addr = addr;
                bus_c.req_wdata = d[15:0]; bus_c.req_be = be[1:0];
            end
        endcase
        if (wr) begin
            case (dut)
                0: begin
                    m32 = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                    ma[addr] = (ma[addr] & ~m32) | (d & m32);
                end
                1: if (be[0] && addr < 4'd10) mb[addr] = d[7:0];
                default: begin
                    m16 = {{8{be[1]}}, {8{be[0]}}};
                    mc[addr] = (mc[addr] & ~m16) | (d[15:0] & m16);
                end
            endcase
        end else begin
            case (dut)
                0: begin e.data = ma[addr]; e.cyc = cyc_now() + 1; qa.push_back(e); end
                1: begin
                    e.data = (addr < 4'd10) ? {24'h0, mb[addr]} : 32'h0;
                    e.cyc  = cyc_now() + 2;
                    qb.push_back(e);
                end
                default: begin e.data = {16'h0, mc[addr]}; e.cyc = cyc_now() + 1; qc.push_back(e); end
            endcase
        end
        @(negedge clk);
        case (dut)
            0:       bus_a.req_valid = 1'b0;
            1:       bus_b.req_valid = 1'b0;
            default: bus_c.req_valid = 1'b0;
        endcase
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_a.rsp_valid === 1'b1) begin
                vectors++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_a t=%0t: got unexpected response %h, want none", $time, bus_a.rsp_rdata);
                end else begin
                    e = qa.pop_front();
                    if (bus_a.rsp_rdata !== e.data || cyc_now() != e.cyc) begin
                        errors++;
                        $display("FAIL rsp_a t=%0t: got %h at edge %0d, want %h at edge %0d",
                                 $time, bus_a.rsp_rdata, cyc_now(), e.data, e.cyc);
                    end
                end
            end
            if (bus_b.rsp_valid === 1'b1) begin
                vectors++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_b t=%0t: got unexpected response %h, want none", $time, bus_b.rsp_rdata);
                end else begin
                    e = qb.pop_front();
                    if ({24'h0, bus_b.rsp_rdata} !== e.data || cyc_now() != e.cyc) begin
                        errors++;
                        $display("FAIL rsp_b t=%0t: got %h at edge %0d, want %h at edge %0d",
                                 $time, bus_b.rsp_rdata, cyc_now(), e.data, e.cyc);
                    end
                end
            end
            if (bus_c.rsp_valid === 1'b1) begin
                vectors++;
                if (qc.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_c t=%0t: got unexpected response %h, want none", $time, bus_c.rsp_rdata);
                end else begin
                    e = qc.pop_front();
                    if ({16'h0, bus_c.rsp_rdata} !== e.data || cyc_now() != e.cyc) begin
                        errors++;
                        $display("FAIL rsp_c t=%0t: got %h at edge %0d, want %h at edge %0d",
                                 $time, bus_c.rsp_rdata, cyc_now(), e.data, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        vectors++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d/%0d/%0d responses outstanding, want 0/0/0",
                     tag, qa.size(), qb.size(), qc.size());
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        idle(2);
        vectors++;
        if ({bus_a.rsp_valid, bus_a.req_ready, busy_a} !== 3'b000 || bus_a.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: got valid=%b ready=%b busy=%b data=%h, want 0 0 0 0",
                     bus_a.rsp_valid, bus_a.req_ready, busy_a, bus_a.rsp_rdata);
        end
        vectors++;
        if ({bus_b.rsp_valid, bus_b.req_ready, busy_b} !== 3'b000 || bus_b.rsp_rdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_b: got valid=%b ready=%b busy=%b data=%h, want 0 0 0 0",
                     bus_b.rsp_valid, bus_b.req_ready, busy_b, bus_b.rsp_rdata);
        end
        vectors++;
        if ({bus_c.rsp_valid, bus_c.req_ready, busy_c} !== 3'b000 || bus_c.rsp_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_c: got valid=%b ready=%b busy=%b data=%h, want 0 0 0 0",
                     bus_c.rsp_valid, bus_c.req_ready, busy_c, bus_c.rsp_rdata);
        end
        foreach (ma[i]) ma[i] = '0;
        foreach (mb[i]) mb[i] = '0;
        foreach (mc[i]) mc[i] = 'x;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if (busy_a !== (k < 16) || bus_a.req_ready !== (k >= 16)) begin
                errors++;
                $display("FAIL clear_a k=%0d: got busy=%b ready=%b, want busy=%b ready=%b",
                         k, busy_a, bus_a.req_ready, (k < 16), (k >= 16));
            end
            vectors++;
            if (busy_b !== (k < 10) || bus_b.req_ready !== (k >= 10)) begin
                errors++;
                $display("FAIL clear_b k=%0d: got busy=%b ready=%b, want busy=%b ready=%b",
                         k, busy_b, bus_b.req_ready, (k < 10), (k >= 10));
            end
            vectors++;
            if (busy_c !== 1'b0 || bus_c.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL noclear_c k=%0d: got busy=%b ready=%b, want busy=0 ready=1",
                         k, busy_c, bus_c.req_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < 16; i++) op(0, 1'b0, 4'(i), 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) op(1, 1'b0, 4'(i), 32'h0, 4'h0);
        drain("clear_readback");
    endtask

    task automatic test_byte_enable();
        op(0, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111);
        op(0, 1'b1, 4'd3, 32'h11223344, 4'b0101);
        op(0, 1'b0, 4'd3, 32'h0, 4'h0);
        op(2, 1'b1, 4'd5, 32'h1234, 4'b0011);
        op(2, 1'b1, 4'd5, 32'hABCD, 4'b0010);
        op(2, 1'b0, 4'd5, 32'h0, 4'h0);
        drain("byte_enable");
    endtask

    task automatic test_raw_latency();
        op(0, 1'b1, 4'd7, 32'h5A, 4'h1);
        op(0, 1'b0, 4'd7, 32'h0, 4'h0);
        op(1, 1'b1, 4'd7, 32'h5A, 4'h1);
        op(1, 1'b0, 4'd7, 32'h0, 4'h0);
        idle(3);
        vectors++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_rdata !== 32'h0000005A) begin
            errors++;
            $display("FAIL hold_a: got valid=%b data=%h, want valid=0 data=0000005a",
                     bus_a.rsp_valid, bus_a.rsp_rdata);
        end
        vectors++;
        if (bus_b.rsp_valid !== 1'b0 || bus_b.rsp_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL hold_b: got valid=%b data=%h, want valid=0 data=5a",
                     bus_b.rsp_valid, bus_b.rsp_rdata);
        end
        drain("raw_latency");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 16; i++) op(0, 1'b1, 4'(i), 32'(i * 3), 4'hF);
        for (int i = 0; i < 16; i++) op(0, 1'b0, 4'(i), 32'h0, 4'h0);
        drain("stream");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            op(1, 1'b1, 4'(i), 32'(8'h80 + i), 4'h1);
            op(1, 1'b0, 4'(i), 32'h0, 4'h0);
        end
        drain("back_to_back");
    endtask

    task automatic test_bounds();
        op(1, 1'b1, 4'd12, 32'hFF, 4'h1);
        op(1, 1'b0, 4'd12, 32'h0, 4'h0);
        op(1, 1'b0, 4'd2, 32'h0, 4'h0);
        op(1, 1'b1, 4'd9, 32'h99, 4'h1);
        op(1, 1'b0, 4'd9, 32'h0, 4'h0);
        op(1, 1'b0, 4'd15, 32'h0, 4'h0);
        drain("bounds");
    endtask

    task automatic test_reset_mid();
        // Read accepted at edge E, reset at E+1: the response must never appear.
        bus_b.req_valid = 1'b1; bus_b.req_wr = 1'b0; bus_b.req_addr = 4'd4;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        rst_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (bus_b.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_b k=%0d: got rsp_valid=%b, want 0", k, bus_b.rsp_valid);
            end
        end
        rst_b = 1'b0;
        idle(4);
        rst_b = 1'b1;
        @(negedge clk);
        foreach (mb[i]) mb[i] = '0;
        rst_b = 1'b0;
        #1;
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if (busy_b !== (k < 10)) begin
                errors++;
                $display("FAIL restart_b k=%0d: got busy=%b, want %b", k, busy_b, (k < 10));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) op(1, 1'b0, 4'(i), 32'h0, 4'h0);
        drain("reset_mid");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by t=%0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_wr = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.req_be = '0;
        bus_b.req_valid = 1'b0; bus_b.req_wr = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.req_be = '0;
        bus_c.req_valid = 1'b0; bus_c.req_wr = 1'b0; bus_c.req_addr = '0; bus_c.req_wdata = '0; bus_c.req_be = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_clear_readback();
        test_byte_enable();
        test_raw_latency();
        test_stream();
        test_back_to_back();
        test_bounds();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
